// File: rtl/uart_receive.sv
// UART receiver: 8 data bits, LSB first, one stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit after data bit 7.
module uart_receive #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s, rx_prev;
  logic [CW-1:0] clk_count, count_next;
  logic [2:0]    bit_index, index_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_next;
  logic          valid_next, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic          parity_bad, parity_bad_next, parity_err_next;
`endif

  // rx_prev is the delayed synchronized line used for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so each flop captures the previous stage's old value.
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift_reg <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      clk_count <= count_next;
      bit_index <= index_next;
      shift_reg <= shift_next;
      data      <= data_next;
      valid     <= valid_next;
      frame_err <= frame_err_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_bad <= parity_bad_next;
      parity_err <= parity_err_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next      = state;
    count_next      = clk_count;
    index_next      = bit_index;
    shift_next      = shift_reg;
    data_next       = data;
    valid_next      = 1'b0;
    frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_next = parity_bad;
    parity_err_next = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        count_next = '0;
        index_next = '0;
        if (rx_prev && !rx_s) state_next = START;
      end

      // A start bit that is high again at mid-bit is treated as a glitch.
      START: begin
        if (clk_count == HALF_END) begin
          count_next = '0;
          index_next = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          count_next = clk_count + 1'b1;
        end
      end

      DATA: begin
        if (clk_count == BIT_END) begin
          count_next            = '0;
          shift_next[bit_index] = rx_s;
          if (bit_index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            index_next = bit_index + 3'd1;
          end
        end else begin
          count_next = clk_count + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: the data bits and the parity bit together hold an even count of ones.
      PARITY: begin
        if (clk_count == BIT_END) begin
          count_next      = '0;
          parity_bad_next = ((^shift_reg) != rx_s);
          state_next      = STOP;
        end else begin
          count_next = clk_count + 1'b1;
        end
      end
`endif

      // Framing error takes precedence over a parity error; data only updates on a clean frame.
      STOP: begin
        if (clk_count == BIT_END) begin
          count_next = '0;
          state_next = IDLE;
          if (!rx_s) begin
            frame_err_next = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bad) begin
            parity_err_next = 1'b1;
`endif
          end else begin
            valid_next = 1'b1;
            data_next  = shift_reg;
          end
        end else begin
          count_next = clk_count + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboard bench for uart_receive: directed frames plus randomized frames,
// expected outcomes derived from the frame contents (define UART_RX_PARITY_EN for 8E1).
module tb_uart_receive;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 4_000_000;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_MAX  = (21 * CPB) / 2 + 4;
`else
  localparam int LAT_MAX  = (19 * CPB) / 2 + 4;
`endif

  typedef enum int {EV_VALID = 0, EV_FERR = 1, EV_PERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] value;
    int         t_fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, busy, frame_err, parity_err;

  int         cyc    = 0;
  int         n_cmp  = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;

  uart_receive #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Predicts the frame's outcome from its contents, then drives it onto the line.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip);
    exp_t e;
    logic bad_par;
    bad_par = pflip;
`ifndef UART_RX_PARITY_EN
    bad_par = 1'b0;
`endif
    e.value  = b;
    e.t_fall = cyc;
    if (!stop)        e.kind = EV_FERR;
    else if (bad_par) e.kind = EV_PERR;
    else              e.kind = EV_VALID;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ bad_par);
`endif
    drive_bit(stop);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_good = 8'h00;
      end else if (valid || frame_err || parity_err) begin
        exp_t     e;
        ev_kind_t got;
        got = valid ? EV_VALID : (frame_err ? EV_FERR : EV_PERR);
        check("pulse_onehot", 32'($countones({valid, frame_err, parity_err})), 32'd1);
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0b frame_err=%0b parity_err=%0b, want no pulse",
                   valid, frame_err, parity_err);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", 32'(got), 32'(e.kind));
          if (e.kind == EV_VALID) begin
            check("rx_byte", {24'h0, data}, {24'h0, e.value});
            check("latency_in_bound", 32'((cyc - e.t_fall) <= LAT_MAX), 32'd1);
            last_good = e.value;
          end else begin
            check("data_hold", {24'h0, data}, {24'h0, last_good});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic       stop, pflip;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",       {24'h0, data}, 32'h0);
    check("reset_valid",      {31'h0, valid}, 32'h0);
    check("reset_busy",       {31'h0, busy}, 32'h0);
    check("reset_frame_err",  {31'h0, frame_err}, 32'h0);
    check("reset_parity_err", {31'h0, parity_err}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(8'h75, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("busy_after_0x75", {31'h0, busy}, 32'h0);

    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);

    // 100 ns glitch on an idle line.
    rx = 1'b0;
    repeat (6) @(negedge clk);
    check("glitch_busy_rises", {31'h0, busy}, 32'h1);
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("glitch_busy_falls", {31'h0, busy}, 32'h0);
    check("glitch_data_kept", {24'h0, data}, 32'hFF);

    // Stop bit low, then the line stays low for two more bit times.
    send_frame(8'hA5, 1'b0, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("low_line_no_retrigger", {31'h0, busy}, 32'h0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("ferr_data_kept", {24'h0, data}, 32'hFF);

    // Reset during data bit 4 of 0x3C; the sender abandons the frame too.
    b = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("abort_data_cleared", {24'h0, data}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    send_frame(8'hC3, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h75, 1'b1, 1'b0);
    send_frame(8'h75, 1'b1, 1'b1);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
`endif

    for (int n = 0; n < 40; n++) begin
      b     = 8'($urandom);
      stop  = ($urandom_range(3) != 0);
      pflip = ($urandom_range(3) == 0);
      send_frame(b, stop, pflip);
      if (!stop) begin
        repeat ($urandom_range(2 * CPB)) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
      end else begin
        rx = 1'b1;
        repeat ($urandom_range(CPB)) @(negedge clk);
      end
    end

    for (int i = 0; i < 20 * CPB && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (CPB) @(negedge clk);
    check("final_idle", {31'h0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
